sdiv_q_cbt_axis: RTL and testbench
==================================

// Module: sdiv_q_cbt_axis
// PURPOSE
//  Fixed-latency iterative divider (shift/compare/subtract, no DSPs), DW/DW -> QI.QF quotient,
//  AXIS-like handshakes. Generalises the udiv_q_cbt_axis line with a signed mode, round-to-nearest,
//  saturation/overflow flag, a tuser sideband and a 2-entry output FIFO. Operands are registered on accept.
// PARAMETERS
//  DW     16  dividend/divisor/remainder width
//  QI     16  quotient integer bits
//  QF      8  quotient fractional bits
//  UW      8  sideband width, passed through unchanged
//  SIGNED  0  0: unsigned operands/result; 1: two's complement
//  ROUND   0  0: truncate toward zero; 1: round half away from zero
// PORTS
//  clk                 in   1      clock
//  rst                 in   1      synchronous, active-high reset
//  s_axis_tvalid       in   1      input valid
//  s_axis_tready       out  1      input ready
//  s_axis_dividend     in   DW     dividend
//  s_axis_divisor      in   DW     divisor
//  s_axis_tuser        in   UW     sideband
//  m_axis_tvalid       out  1      output valid (FIFO not empty)
//  m_axis_tready       in   1      output ready
//  m_axis_q_int        out  QI     quotient integer part
//  m_axis_q_frac       out  QF     quotient fractional part
//  m_axis_remainder    out  DW     remainder, sign of dividend when SIGNED=1
//  m_axis_div_by_zero  out  1      divisor was 0
//  m_axis_overflow     out  1      result saturated
//  m_axis_tuser        out  UW     sideband of this result
//  busy                out  1      state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, FIFO emptied; all outputs 0 except s_axis_tready=1 the cycle after rst drops.
//    rst mid-operation aborts the division; no result is emitted.
//  - FSM: IDLE -> CALC (N = DW+QF+ROUND cycles, one quotient bit per cycle) -> FIN (1 cycle) -> IDLE.
//  - s_axis_tready = (state==IDLE) && (fifo_count<2). Fire captures operands+tuser, enters CALC.
//    Holding room at accept guarantees the FIN write never overflows the FIFO.
//  - Magnitudes: |a|,|b| as DW-bit unsigned (SIGNED=1: |-2^(DW-1)| = 2^(DW-1)); neg = SIGNED & (sa^sb).
//  - raw = floor(|a|*2^(QF+ROUND)/|b|), DW+QF+ROUND bits; rem_mag = |a|*2^(QF+ROUND) - raw*|b|.
//  - ROUND=1: mag = (raw+1)>>1, else mag = raw. Result = neg ? -mag : mag in QI+QF bits.
//  - Saturation in FIN: unsigned max 2^(QI+QF)-1; signed range [-2^(QI+QF-1), 2^(QI+QF-1)-1].
//    Out of range -> clamp to bound of correct sign, overflow=1. -0 yields 0.
//  - Remainder = rem_mag, negated if SIGNED and dividend negative.
//  - Divisor 0: still takes full latency; dz=1, overflow=0, remainder=dividend;
//    q = unsigned: all ones; signed: max positive if dividend>=0 else min negative.
//  - FIN writes {q,rem,dz,ovf,tuser} to FIFO; m_axis_tvalid rises next cycle if FIFO was empty.
//    Latency accept-edge -> m_axis_tvalid = N+2 cycles. Throughput 1 per N+2 cycles, no backpressure.
//  - FIFO: 2 entries, in order; write and read in same cycle allowed; outputs stable while
//    m_axis_tvalid=1 and m_axis_tready=0.
// TESTING (DW=16,QI=16,QF=8,UW=8)
//  1 U,trunc: 7/2 tuser=0x11 -> q_int=0x0003 q_frac=0x80 rem=0 tuser=0x11; tvalid exactly 26 cycles after accept.
//  2 ROUND=1: 2/3 -> q_frac=0xAB, rem=1; ROUND=0: 2/3 -> q_frac=0xAA, rem=2.
//  3 SIGNED=1: -7/3 -> q={0xFFFD,0xAB} (-597), rem=0xFFFF; -32768/-1 -> {0x7FFF,0xFF}, overflow=1.
//  4 Zero: U 5/0 -> {0xFFFF,0xFF} dz=1; SIGNED -5/0 -> {0x8000,0x00} dz=1.
//  5 Backpressure: m_tready=0, offer 3 ops tuser 1,2,3 -> 2 accepted, tready stays 0;
//    release tready -> results 1,2 then 3 in order, values correct.
//  6 rst asserted mid-CALC -> no tvalid afterwards; next op after reset completes correctly.

Source files
------------

// File: rtl/sdiv_q_cbt_axis.sv
// sdiv_q_cbt_axis
// Fixed-latency shift/compare/subtract divider producing a QI.QF quotient
// from DW-bit operands. It takes one quotient bit per cycle and uses no
// multipliers.
//
// Options:
//   - signed (two's complement) or unsigned operation
//   - truncation toward zero, or round half away from zero
//   - saturation with an overflow flag
//   - divide-by-zero flag
//   - UW-bit sideband carried alongside each operation
//
// Results land in a 2-entry output FIFO. A new operation is accepted only
// while the FIFO is guaranteed to have room for its result, so the write
// path never needs a full check.
//
// Pipeline per operation:
//   accept (operands registered) -> CALC, N = DW+QF+ROUND cycles
//   -> FIN, result formatted and registered -> FIFO write.
// Latency from the accept edge to m_axis_tvalid is N+2 cycles.
// Throughput is one result every N+2 cycles.
module sdiv_q_cbt_axis #(
    parameter int DW     = 16,
    parameter int QI     = 16,
    parameter int QF     = 8,
    parameter int UW     = 8,
    parameter int SIGNED = 0,
    parameter int ROUND  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic [DW-1:0] s_axis_dividend,
    input  logic [DW-1:0] s_axis_divisor,
    input  logic [UW-1:0] s_axis_tuser,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [QI-1:0] m_axis_q_int,
    output logic [QF-1:0] m_axis_q_frac,
    output logic [DW-1:0] m_axis_remainder,
    output logic          m_axis_div_by_zero,
    output logic          m_axis_overflow,
    output logic [UW-1:0] m_axis_tuser,
    output logic          busy
);

    // Fraction bits actually computed: one extra guard bit when rounding.
    localparam int FB   = QF + ROUND;
    // Quotient bits produced, one per CALC cycle.
    localparam int N    = DW + FB;
    // Width of the formatted quotient.
    localparam int QW   = QI + QF;
    // Wide enough to hold the rounded magnitude and the largest limit.
    localparam int CW   = ((N + 1) > (QW + 1)) ? (N + 1) : (QW + 1);
    localparam int CNTW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    // One completed division as stored in the output FIFO.
    typedef struct packed {
        logic [QW-1:0] q;
        logic [DW-1:0] rem;
        logic          dz;
        logic          ovf;
        logic [UW-1:0] user;
    } res_t;

    state_t state;
    state_t state_nxt;

    // ---------------- operand and iteration registers ----------------
    logic [DW-1:0]   a_raw_r;   // dividend as offered; returned on divide-by-zero
    logic [DW-1:0]   b_mag_r;   // |divisor|
    logic            a_neg_r;   // dividend negative (signed mode only)
    logic            neg_r;     // quotient negative (signed mode only)
    logic            dz_r;      // divisor was zero
    logic [UW-1:0]   user_r;
    logic [N-1:0]    num_r;     // numerator bits shift out, quotient bits shift in
    logic [DW-1:0]   rem_r;     // partial remainder, always < |divisor|
    logic [CNTW-1:0] cnt_r;

    // ---------------- input-side combinational signals ----------------
    logic            accept;
    logic            a_sgn;
    logic            b_sgn;
    logic [DW-1:0]   a_mag;
    logic [DW-1:0]   b_mag;
    logic            calc_done;

    // ---------------- one restoring-division step ----------------
    logic [DW:0]     trial;
    logic [DW-1:0]   diff;
    logic            q_bit;
    logic [DW-1:0]   rem_step;

    // ---------------- FIN formatting ----------------
    logic [CW-1:0]   mag_c;
    logic [CW-1:0]   lim_c;
    logic            ovf_c;
    logic [QW-1:0]   qmag_c;
    res_t            res_c;

    // Staging register between FIN and the FIFO write.
    res_t            res_r;
    logic            res_vld;

    // ---------------- output FIFO ----------------
    res_t            mem [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;
    logic [1:0]      level;
    logic            fifo_rd;
    res_t            head;

    // A staged result counts as occupied, so an accepted operation always has
    // a free slot by the time its own result is written.
    assign level         = count + {1'b0, res_vld};
    assign s_axis_tready = !rst && (state == IDLE) && (level < 2'd2);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign busy          = (state != IDLE);
    assign calc_done     = (cnt_r == CNTW'(N - 1));

    // Operand magnitudes. The most negative value maps to 2^(DW-1), which
    // still fits in DW unsigned bits.
    assign a_sgn = (SIGNED != 0) && s_axis_dividend[DW-1];
    assign b_sgn = (SIGNED != 0) && s_axis_divisor[DW-1];
    assign a_mag = a_sgn ? (DW'(0) - s_axis_dividend) : s_axis_dividend;
    assign b_mag = b_sgn ? (DW'(0) - s_axis_divisor) : s_axis_divisor;

    // State register.
    // NOTE: sequential state is assigned with <= so every flop samples
    // pre-edge values; a blocking = here would create order-dependent
    // races between always blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> CALC on accept, CALC for N cycles, FIN for one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (calc_done) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One restoring step: shift the next numerator bit into the remainder,
    // then subtract the divisor if it fits.
    always_comb begin
        trial    = {rem_r, num_r[N-1]};
        // trial - |b| is < |b| whenever it is kept, so DW bits are enough.
        diff     = trial[DW-1:0] - b_mag_r;
        q_bit    = (trial >= {1'b0, b_mag_r});
        rem_step = q_bit ? diff : trial[DW-1:0];
    end

    // Operand capture on accept, then one quotient bit per CALC cycle.
    // NOTE: datapath registers carry no reset. They are always loaded on
    // accept before being read, and a reset returns control to IDLE, which
    // discards whatever they hold.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (accept) begin
                    a_raw_r <= s_axis_dividend;
                    b_mag_r <= b_mag;
                    a_neg_r <= a_sgn;
                    neg_r   <= a_sgn ^ b_sgn;
                    dz_r    <= (s_axis_divisor == '0);
                    user_r  <= s_axis_tuser;
                    num_r   <= N'(a_mag) << FB;
                    rem_r   <= '0;
                    cnt_r   <= '0;
                end
            end
            CALC: begin
                num_r <= {num_r[N-2:0], q_bit};
                rem_r <= rem_step;
                cnt_r <= cnt_r + CNTW'(1);
            end
            default: ;
        endcase
    end

    // Result formatting: rounding, saturation, sign, and the zero-divisor case.
    always_comb begin
        // Rounding adds half an LSB using the guard bit, then drops it.
        if (ROUND != 0) begin
            mag_c = (CW'(num_r) + CW'(1)) >> 1;
        end else begin
            mag_c = CW'(num_r);
        end

        // Largest magnitude representable with the result's sign.
        if (SIGNED != 0) begin
            lim_c = neg_r ? (CW'(1) << (QW - 1))
                          : ((CW'(1) << (QW - 1)) - CW'(1));
        end else begin
            lim_c = (CW'(1) << QW) - CW'(1);
        end

        ovf_c  = (mag_c > lim_c);
        qmag_c = ovf_c ? lim_c[QW-1:0] : mag_c[QW-1:0];

        // Negating a zero magnitude yields zero, so -0 is never produced.
        res_c.q    = neg_r ? (QW'(0) - qmag_c) : qmag_c;
        res_c.rem  = a_neg_r ? (DW'(0) - rem_r) : rem_r;
        res_c.dz   = 1'b0;
        res_c.ovf  = ovf_c;
        res_c.user = user_r;

        if (dz_r) begin
            res_c.dz  = 1'b1;
            res_c.ovf = 1'b0;
            res_c.rem = a_raw_r;
            if (SIGNED != 0) begin
                res_c.q = a_neg_r ? (QW'(1) << (QW - 1))
                                  : ((QW'(1) << (QW - 1)) - QW'(1));
            end else begin
                res_c.q = {QW{1'b1}};
            end
        end
    end

    // Register the formatted result at the end of FIN, then hand it to the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_vld <= 1'b0;
        end else begin
            res_vld <= (state == FIN);
        end
        if (state == FIN) begin
            res_r <= res_c;
        end
    end

    assign fifo_rd = m_axis_tvalid && m_axis_tready;

    // Two-entry in-order FIFO. Write and read may occur in the same cycle.
    // NOTE: this small memory is reset so that every output reads 0 after
    // reset instead of stale contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (res_vld) begin
                mem[wr_ptr] <= res_r;
                wr_ptr      <= ~wr_ptr;
            end
            if (fifo_rd) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, res_vld} - {1'b0, fifo_rd};
        end
    end

    // The head entry drives the outputs and stays put until it is read.
    assign head               = mem[rd_ptr];
    assign m_axis_tvalid      = (count != 2'd0);
    assign m_axis_q_int       = head.q[QW-1:QF];
    assign m_axis_q_frac      = head.q[QF-1:0];
    assign m_axis_remainder   = head.rem;
    assign m_axis_div_by_zero = head.dz;
    assign m_axis_overflow    = head.ovf;
    assign m_axis_tuser       = head.user;

endmodule

// File: tb/tb_sdiv_q_cbt_axis.sv
// tb_sdiv_q_cbt_axis
// Directed bench for sdiv_q_cbt_axis with DW=16, QI=16, QF=8, UW=8.
// Three instances are built:
//   0: unsigned, truncate
//   1: unsigned, round
//   2: signed, truncate
// Operands and sideband are shared; handshakes are per instance.
module tb_sdiv_q_cbt_axis;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dividend = '0;
    logic [15:0] divisor  = '0;
    logic [7:0]  tuser    = '0;

    logic        s_valid [NI];
    logic        s_ready [NI];
    logic        m_valid [NI];
    logic        m_ready [NI];
    logic [15:0] q_int   [NI];
    logic [7:0]  q_frac  [NI];
    logic [15:0] rem     [NI];
    logic        dz      [NI];
    logic        ovf     [NI];
    logic [7:0]  m_user  [NI];
    logic        busy    [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sdiv_q_cbt_axis #(
            .DW     (16),
            .QI     (16),
            .QF     (8),
            .UW     (8),
            .SIGNED ((g == 2) ? 1 : 0),
            .ROUND  ((g == 1) ? 1 : 0)
        ) u_dut (
            .clk                (clk),
            .rst                (rst),
            .s_axis_tvalid      (s_valid[g]),
            .s_axis_tready      (s_ready[g]),
            .s_axis_dividend    (dividend),
            .s_axis_divisor     (divisor),
            .s_axis_tuser       (tuser),
            .m_axis_tvalid      (m_valid[g]),
            .m_axis_tready      (m_ready[g]),
            .m_axis_q_int       (q_int[g]),
            .m_axis_q_frac      (q_frac[g]),
            .m_axis_remainder   (rem[g]),
            .m_axis_div_by_zero (dz[g]),
            .m_axis_overflow    (ovf[g]),
            .m_axis_tuser       (m_user[g]),
            .busy               (busy[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation on instance k; returns just after its accept edge.
    task automatic offer(input int k, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] u, input string tag);
        int n;
        n = 0;
        dividend   = a;
        divisor    = b;
        tuser      = u;
        s_valid[k] = 1'b1;
        while (!s_ready[k] && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_accept"}, 64'(s_ready[k]), 64'd1);
        tick();
        s_valid[k] = 1'b0;
    endtask

    // Count cycles until instance k shows a valid result, bounded.
    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        while (!m_valid[k] && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    // Wait for, check, and pop one result from instance k.
    task automatic expect_res(input int k, input string tag,
                              input logic [15:0] eqi, input logic [7:0] eqf,
                              input logic [15:0] erem, input logic edz,
                              input logic eovf, input logic [7:0] eu);
        int lat;
        wait_valid(k, lat);
        check({tag, "_valid"}, 64'(m_valid[k]), 64'd1);
        check({tag, "_qint"},  64'(q_int[k]),   64'(eqi));
        check({tag, "_qfrac"}, 64'(q_frac[k]),  64'(eqf));
        check({tag, "_rem"},   64'(rem[k]),     64'(erem));
        check({tag, "_dz"},    64'(dz[k]),      64'(edz));
        check({tag, "_ovf"},   64'(ovf[k]),     64'(eovf));
        check({tag, "_user"},  64'(m_user[k]),  64'(eu));
        m_ready[k] = 1'b1;
        tick();
        m_ready[k] = 1'b0;
    endtask

    // Hard stop in case the sequence itself wedges.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int seen;

        for (int i = 0; i < NI; i++) begin
            s_valid[i] = 1'b0;
            m_ready[i] = 1'b0;
        end

        // ---- reset ----
        rst = 1'b1;
        repeat (3) tick();
        check("rst_tready_held", 64'(s_ready[0]), 64'd0);
        check("rst_tvalid",      64'(m_valid[0]), 64'd0);
        check("rst_busy",        64'(busy[0]),    64'd0);
        rst = 1'b0;
        #1;
        check("rst_tready_rel",  64'(s_ready[0]), 64'd1);
        tick();
        check("rst_tready_on",   64'(s_ready[0]), 64'd1);
        check("rst_qint",        64'(q_int[0]),   64'd0);
        check("rst_rem",         64'(rem[0]),     64'd0);
        check("rst_user",        64'(m_user[0]),  64'd0);

        // ---- unsigned truncate: 7/2 = 3.5, latency N+2 = 26 ----
        offer(0, 16'd7, 16'd2, 8'h11, "t1");
        check("t1_busy", 64'(busy[0]), 64'd1);
        wait_valid(0, lat);
        check("t1_latency", 64'(lat), 64'd26);
        expect_res(0, "t1", 16'h0003, 8'h80, 16'h0000, 1'b0, 1'b0, 8'h11);
        check("t1_empty", 64'(m_valid[0]), 64'd0);

        // ---- rounding vs truncation ----
        // 2/3 = 0.666..: rounded 0xAB rem 1, truncated 0xAA rem 2.
        offer(1, 16'd2, 16'd3, 8'h21, "t2r");
        wait_valid(1, lat);
        check("t2r_latency", 64'(lat), 64'd27);
        expect_res(1, "t2r", 16'h0000, 8'hAB, 16'h0001, 1'b0, 1'b0, 8'h21);
        offer(0, 16'd2, 16'd3, 8'h22, "t2t");
        expect_res(0, "t2t", 16'h0000, 8'hAA, 16'h0002, 1'b0, 1'b0, 8'h22);
        // 1/512 is exactly half an LSB: rounds up to 0x01, truncates to 0 rem 256.
        offer(1, 16'd1, 16'd512, 8'h23, "t2h");
        expect_res(1, "t2h", 16'h0000, 8'h01, 16'h0000, 1'b0, 1'b0, 8'h23);
        offer(0, 16'd1, 16'd512, 8'h24, "t2z");
        expect_res(0, "t2z", 16'h0000, 8'h00, 16'h0100, 1'b0, 1'b0, 8'h24);

        // ---- signed ----
        // -7/3 = -597/256, remainder takes the dividend's sign.
        offer(2, 16'hFFF9, 16'd3, 8'h31, "t3a");
        wait_valid(2, lat);
        check("t3a_latency", 64'(lat), 64'd26);
        expect_res(2, "t3a", 16'hFFFD, 8'hAB, 16'hFFFF, 1'b0, 1'b0, 8'h31);
        // -32768/-1 saturates to the positive limit.
        offer(2, 16'h8000, 16'hFFFF, 8'h32, "t3b");
        expect_res(2, "t3b", 16'h7FFF, 8'hFF, 16'h0000, 1'b0, 1'b1, 8'h32);
        // 7/-2 = -3.5
        offer(2, 16'd7, 16'hFFFE, 8'h33, "t3c");
        expect_res(2, "t3c", 16'hFFFC, 8'h80, 16'h0000, 1'b0, 1'b0, 8'h33);
        // -32768/1 is exactly the negative limit, no overflow.
        offer(2, 16'h8000, 16'd1, 8'h34, "t3d");
        expect_res(2, "t3d", 16'h8000, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h34);

        // ---- divide by zero ----
        offer(0, 16'd5, 16'd0, 8'h41, "t4u");
        expect_res(0, "t4u", 16'hFFFF, 8'hFF, 16'h0005, 1'b1, 1'b0, 8'h41);
        offer(2, 16'hFFFB, 16'd0, 8'h42, "t4n");
        expect_res(2, "t4n", 16'h8000, 8'h00, 16'hFFFB, 1'b1, 1'b0, 8'h42);
        offer(2, 16'd5, 16'd0, 8'h43, "t4p");
        expect_res(2, "t4p", 16'h7FFF, 8'hFF, 16'h0005, 1'b1, 1'b0, 8'h43);

        // ---- backpressure: two results fill the FIFO, the third is refused ----
        m_ready[0] = 1'b0;
        offer(0, 16'd10, 16'd4, 8'd1, "t5a");
        offer(0, 16'd9,  16'd3, 8'd2, "t5b");
        dividend   = 16'd100;
        divisor    = 16'd7;
        tuser      = 8'd3;
        s_valid[0] = 1'b1;
        seen = 0;
        repeat (150) begin
            if (s_ready[0]) seen++;
            tick();
        end
        s_valid[0] = 1'b0;
        check("t5_no_accept", 64'(seen), 64'd0);
        check("t5_full_valid", 64'(m_valid[0]), 64'd1);
        check("t5_head_hold", 64'(m_user[0]), 64'd1);
        expect_res(0, "t5r1", 16'h0002, 8'h80, 16'h0000, 1'b0, 1'b0, 8'd1);
        expect_res(0, "t5r2", 16'h0003, 8'h00, 16'h0000, 1'b0, 1'b0, 8'd2);
        offer(0, 16'd100, 16'd7, 8'd3, "t5c");
        expect_res(0, "t5r3", 16'h000E, 8'h49, 16'h0001, 1'b0, 1'b0, 8'd3);

        // ---- reset mid-CALC aborts the operation ----
        offer(0, 16'd1000, 16'd10, 8'h55, "t6a");
        repeat (10) tick();
        check("t6_busy_mid", 64'(busy[0]), 64'd1);
        rst = 1'b1;
        tick();
        tick();
        check("t6_busy_rst", 64'(busy[0]), 64'd0);
        check("t6_tready_rst", 64'(s_ready[0]), 64'd0);
        rst = 1'b0;
        seen = 0;
        repeat (60) begin
            tick();
            if (m_valid[0]) seen++;
        end
        check("t6_no_result", 64'(seen), 64'd0);
        offer(0, 16'd1000, 16'd10, 8'h66, "t6b");
        expect_res(0, "t6b", 16'h0064, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
